// File: rtl/seq_pkg.sv
// Shared types and ctrl_addr field layout for the micro_sequencer block.
package seq_pkg;
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_HALT = 2'd1,
        S_PROG = 2'd2
    } seq_state_e;

    localparam int STEP_W   = 3;
    localparam int ADDR_W   = 9;
    localparam int FLAG_LSB = 7;
    localparam int OP_LSB   = 3;
    localparam int STEP_LSB = 0;

    function automatic logic [ADDR_W-1:0] make_addr(input logic [1:0] flags,
                                                    input logic [3:0] opcode,
                                                    input logic [STEP_W-1:0] step);
        logic [ADDR_W-1:0] a;
        a = '0;
        a[FLAG_LSB +: 2]      = flags;
        a[OP_LSB +: 4]        = opcode;
        a[STEP_LSB +: STEP_W] = step;
        return a;
    endfunction
endpackage

// File: rtl/micro_sequencer_step_counter.sv
// Microstep counter: clear beats increment; wrap marks the last legal step.
module step_counter
    import seq_pkg::*;
#(
    parameter int MAX_STEP = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              clr,
    output logic [STEP_W-1:0] step,
    output logic              wrap
);
    assign wrap = (step == STEP_W'(MAX_STEP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   step <= '0;
        else if (clr) step <= '0;
        else if (inc) step <= step + STEP_W'(1);
    end
endmodule

// File: rtl/micro_sequencer.sv
// Microstep sequencer: RUN/HALT/PROG FSM, latched flags, retired-instruction count.
// Optional SINGLE_STEP_EN adds step_mode/step_req for manual microstep advance.
module micro_sequencer
    import seq_pkg::*;
#(
    parameter int MAX_STEP = 5,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pmode,
    input  logic [3:0]        opcode,
    input  logic              cf_in,
    input  logic              zf_in,
    input  logic              flags_we,
    input  logic              halt_req,
    input  logic              end_instr,
`ifdef SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step_req,
`endif
    output logic [ADDR_W-1:0] ctrl_addr,
    output logic [STEP_W-1:0] step,
    output logic              cw_en,
    output logic              prog_active,
    output logic              halted,
    output logic              pc_clr,
    output logic              instr_done,
    output logic [CNT_W-1:0]  instr_count
);
    seq_state_e state, state_d;
    logic [1:0] flags;
    logic       inc, clr, wrap, retire, flags_ld, flags_clr, pc_clr_d;
    logic       run_go;

`ifdef SINGLE_STEP_EN
    // One-register edge detect; in step mode only the rising-edge cycle may execute.
    logic req_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) req_q <= 1'b0;
        else        req_q <= step_req;
    end
    assign run_go = step_mode ? (step_req & ~req_q) : 1'b1;
`else
    assign run_go = 1'b1;
`endif

    step_counter #(.MAX_STEP(MAX_STEP)) u_step (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc),
        .clr   (clr),
        .step  (step),
        .wrap  (wrap)
    );

    assign cw_en       = (state == S_RUN) && run_go;
    assign halted      = (state == S_HALT);
    assign prog_active = (state == S_PROG);
    assign ctrl_addr   = make_addr(flags, opcode, step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RUN;
        else        state <= state_d;
    end

    always_comb begin
        state_d   = state;
        inc       = 1'b0;
        clr       = 1'b0;
        retire    = 1'b0;
        flags_ld  = 1'b0;
        flags_clr = 1'b0;
        pc_clr_d  = 1'b0;
        if (pmode) begin
            // Abandon whatever was in flight; nothing retires.
            state_d = S_PROG;
            clr     = 1'b1;
        end else begin
            case (state)
                S_RUN: begin
                    if (cw_en) begin
                        flags_ld = flags_we;
                        if (halt_req) begin
                            state_d = S_HALT;
                        end else if (end_instr || wrap) begin
                            clr    = 1'b1;
                            retire = 1'b1;
                        end else begin
                            inc = 1'b1;
                        end
                    end
                end
                S_PROG: begin
                    state_d   = S_RUN;
                    clr       = 1'b1;
                    flags_clr = 1'b1;
                    pc_clr_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags       <= 2'b00;
            pc_clr      <= 1'b0;
            instr_done  <= 1'b0;
            instr_count <= '0;
        end else begin
            pc_clr     <= pc_clr_d;
            instr_done <= retire;
            if (flags_clr)     flags <= 2'b00;
            else if (flags_ld) flags <= {cf_in, zf_in};
            if (retire)        instr_count <= instr_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer (MAX_STEP=5, CNT_W=8).
module tb_micro_sequencer;
    import seq_pkg::*;

    logic clk = 1'b0, rst_n = 1'b0;
    logic pmode = 0, cf_in = 0, zf_in = 0, flags_we = 0, halt_req = 0, end_instr = 0;
    logic [3:0] opcode = 4'b0001;
    logic [ADDR_W-1:0] ctrl_addr;
    logic [STEP_W-1:0] step;
    logic cw_en, prog_active, halted, pc_clr, instr_done;
    logic [7:0] instr_count;
`ifdef SINGLE_STEP_EN
    logic step_mode = 0, step_req = 0;
`endif
    int n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    micro_sequencer #(.MAX_STEP(5), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .pmode(pmode), .opcode(opcode),
        .cf_in(cf_in), .zf_in(zf_in), .flags_we(flags_we),
        .halt_req(halt_req), .end_instr(end_instr),
`ifdef SINGLE_STEP_EN
        .step_mode(step_mode), .step_req(step_req),
`endif
        .ctrl_addr(ctrl_addr), .step(step), .cw_en(cw_en),
        .prog_active(prog_active), .halted(halted), .pc_clr(pc_clr),
        .instr_done(instr_done), .instr_count(instr_count)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 0; pmode = 0; flags_we = 0; halt_req = 0; end_instr = 0;
        cf_in = 0; zf_in = 0; opcode = 4'b0001;
        tick(2);
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (step !== 3'd0) begin n_fail++; $display("FAIL reset_step got %0d exp 0", step); end
        n_checks++; if ({cw_en, halted, prog_active, pc_clr, instr_done} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_flags got %b exp 10000", {cw_en, halted, prog_active, pc_clr, instr_done}); end
        n_checks++; if (instr_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", instr_count); end
        n_checks++; if (ctrl_addr !== 9'b000001000) begin n_fail++; $display("FAIL reset_addr got %b exp 000001000", ctrl_addr); end
    endtask

    task automatic test_run();
        logic [2:0] exp_seq [5];
        exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (step !== exp_seq[i]) begin n_fail++; $display("FAIL run_step[%0d] got %0d exp %0d", i, step, exp_seq[i]); end
            n_checks++; if (instr_done !== (i == 4)) begin n_fail++; $display("FAIL run_done[%0d] got %b exp %b", i, instr_done, (i == 4)); end
        end
        n_checks++; if (instr_count !== 8'd1) begin n_fail++; $display("FAIL run_count got %0d exp 1", instr_count); end
        tick();
        n_checks++; if (instr_done !== 1'b0) begin n_fail++; $display("FAIL run_done_clear got %b exp 0", instr_done); end
    endtask

    task automatic test_end_halt();
        do_reset();
        tick(2);
        end_instr = 1;
        tick();
        end_instr = 0;
        n_checks++; if (step !== 3'd0 || instr_done !== 1'b1 || instr_count !== 8'd1) begin
            n_fail++; $display("FAIL end_instr got step=%0d done=%b cnt=%0d exp 0/1/1", step, instr_done, instr_count); end
        tick(3);
        halt_req = 1; end_instr = 1;
        tick();
        halt_req = 0; end_instr = 0;
        n_checks++; if (halted !== 1'b1 || step !== 3'd3 || cw_en !== 1'b0) begin
            n_fail++; $display("FAIL halt_enter got halted=%b step=%0d cw=%b exp 1/3/0", halted, step, cw_en); end
        n_checks++; if (instr_count !== 8'd1 || instr_done !== 1'b0) begin
            n_fail++; $display("FAIL halt_count got cnt=%0d done=%b exp 1/0", instr_count, instr_done); end
        end_instr = 1;
        tick(3);
        end_instr = 0;
        n_checks++; if (halted !== 1'b1 || step !== 3'd3 || instr_count !== 8'd1) begin
            n_fail++; $display("FAIL halt_stay got halted=%b step=%0d cnt=%0d exp 1/3/1", halted, step, instr_count); end
    endtask

    task automatic test_flags();
        do_reset();
        tick(4);
        flags_we = 1; cf_in = 1; zf_in = 0;
        n_checks++; if (ctrl_addr[8:7] !== 2'b00) begin n_fail++; $display("FAIL flags_pre got %b exp 00", ctrl_addr[8:7]); end
        tick();
        flags_we = 0; cf_in = 0;
        n_checks++; if (ctrl_addr !== 9'b100001000) begin n_fail++; $display("FAIL flags_addr got %b exp 100001000", ctrl_addr); end
        halt_req = 1;
        tick();
        halt_req = 0;
        flags_we = 1; cf_in = 0; zf_in = 1;
        tick(2);
        flags_we = 0; zf_in = 0;
        n_checks++; if (ctrl_addr[8:7] !== 2'b10 || halted !== 1'b1) begin
            n_fail++; $display("FAIL flags_halt got flags=%b halted=%b exp 10/1", ctrl_addr[8:7], halted); end
    endtask

    task automatic test_prog();
        do_reset();
        tick();
        flags_we = 1; cf_in = 1; zf_in = 1;
        tick();
        flags_we = 0; cf_in = 0; zf_in = 0;
        pmode = 1;
        tick();
        n_checks++; if (prog_active !== 1'b1 || step !== 3'd0 || cw_en !== 1'b0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL prog_enter got pa=%b step=%0d cw=%b h=%b exp 1/0/0/0", prog_active, step, cw_en, halted); end
        tick(2);
        n_checks++; if (instr_count !== 8'd0 || instr_done !== 1'b0 || pc_clr !== 1'b0) begin
            n_fail++; $display("FAIL prog_abandon got cnt=%0d done=%b pcclr=%b exp 0/0/0", instr_count, instr_done, pc_clr); end
        pmode = 0;
        tick();
        n_checks++; if (pc_clr !== 1'b1 || prog_active !== 1'b0 || step !== 3'd0 || ctrl_addr[8:7] !== 2'b00 || cw_en !== 1'b1) begin
            n_fail++; $display("FAIL prog_exit got pcclr=%b pa=%b step=%0d flags=%b cw=%b exp 1/0/0/00/1",
                                pc_clr, prog_active, step, ctrl_addr[8:7], cw_en); end
        tick();
        n_checks++; if (pc_clr !== 1'b0 || step !== 3'd1) begin
            n_fail++; $display("FAIL prog_after got pcclr=%b step=%0d exp 0/1", pc_clr, step); end
        halt_req = 1;
        tick();
        halt_req = 0;
        pmode = 1;
        tick();
        pmode = 0;
        n_checks++; if (prog_active !== 1'b1 || halted !== 1'b0) begin
            n_fail++; $display("FAIL prog_from_halt got pa=%b h=%b exp 1/0", prog_active, halted); end
    endtask

    task automatic test_wrap_async_reset();
        do_reset();
        end_instr = 1;
        tick(255);
        n_checks++; if (instr_count !== 8'd255) begin n_fail++; $display("FAIL wrap_255 got %0d exp 255", instr_count); end
        tick();
        n_checks++; if (instr_count !== 8'd0 || instr_done !== 1'b1) begin
            n_fail++; $display("FAIL wrap_0 got cnt=%0d done=%b exp 0/1", instr_count, instr_done); end
        tick(2);
        end_instr = 0;
        tick(3);
        n_checks++; if (step !== 3'd3 || instr_count !== 8'd2) begin
            n_fail++; $display("FAIL wrap_pre got step=%0d cnt=%0d exp 3/2", step, instr_count); end
        #2 rst_n = 0;
        #1;
        n_checks++; if (step !== 3'd0 || instr_count !== 8'd0 || instr_done !== 1'b0 || pc_clr !== 1'b0 ||
                        cw_en !== 1'b1 || halted !== 1'b0 || prog_active !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got step=%0d cnt=%0d done=%b pcclr=%b cw=%b h=%b pa=%b",
                                step, instr_count, instr_done, pc_clr, cw_en, halted, prog_active); end
        tick();
        rst_n = 1;
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_single_step();
        step_mode = 1; step_req = 0;
        do_reset();
        tick(3);
        n_checks++; if (step !== 3'd0 || cw_en !== 1'b0) begin
            n_fail++; $display("FAIL ss_hold got step=%0d cw=%b exp 0/0", step, cw_en); end
        for (int i = 1; i <= 3; i++) begin
            step_req = 1;
            #1;
            n_checks++; if (cw_en !== 1'b1) begin n_fail++; $display("FAIL ss_cw[%0d] got %b exp 1", i, cw_en); end
            tick(3);
            n_checks++; if (step !== 3'(i) || cw_en !== 1'b0) begin
                n_fail++; $display("FAIL ss_adv[%0d] got step=%0d cw=%b exp %0d/0", i, step, cw_en, i); end
            step_req = 0;
            tick();
        end
        step_mode = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_run();
        test_end_halt();
        test_flags();
        test_prog();
        test_wrap_async_reset();
`ifdef SINGLE_STEP_EN
        test_single_step();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
